// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//
// General-purpose register file: two combinational read ports, one synchronous
// write port. Write-to-read bypass and a hardwired zero register are optional.
//
// The storage array has no reset, so it can be mapped onto RAM. Instead, a
// clear sequencer writes zero to one entry per clock. It runs after reset
// release and again whenever clear is requested while the file is ready.
// While the sequencer runs, ready is low, writes are dropped and both read
// ports return zero.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   clear       request to re-zero every entry (honoured only when ready=1)
//   reg_write   write enable
//   write_reg   write address
//   write_data  write data
//   read_reg1   read port 1 address
//   read_reg2   read port 2 address
//   read_data1  read port 1 data (combinational)
//   read_data2  read port 2 data (combinational)
//   ready       1: file usable, 0: clear sequence running
//   clr_idx     entry being cleared this cycle (debug)
// -----------------------------------------------------------------------------
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              ready,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // A user write needs READY, reg_write and no simultaneous clear request.
    // A clear request takes priority over a write in the same cycle, so that write is discarded.
    logic user_write;
    assign user_write = (state_q == READY) && reg_write && !clear;

    // ------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values present before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            CLEAR: begin
                // clr_idx wraps to 0 on the edge that clears the last entry.
                clr_idx_d = clr_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (clr_idx_q == {ADDR_W{1'b1}}) begin
                    state_d = READY;
                end
                // A clear request during CLEAR is ignored. The sweep does not restart.
            end
            READY: begin
                if (clear) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single storage write port, shared by the sequencer and the user
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
        end else if (user_write && !((ZERO_REG != 0) && (write_reg == '0))) begin
            mem_we    = 1'b1;
            mem_waddr = write_reg;
            mem_wdata = write_data;
        end
    end

    // NOTE: the array is deliberately left out of the reset so that it can map
    // onto RAM. The clear sequencer supplies the zero contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // Priority: not ready -> 0, zero register -> 0, bypass -> write_data,
    // otherwise stored value. Each port evaluates this independently.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = '0;
        if (state_q != READY) begin
            value = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            value = '0;
        end else if ((BYPASS != 0) && user_write && (addr == write_reg)) begin
            value = write_data;
        end else begin
            value = mem[addr];
        end
        return value;
    endfunction

    always_comb begin
        read_data1 = read_port(read_reg1);
        read_data2 = read_port(read_reg2);
    end

    assign ready   = (state_q == READY);
    assign clr_idx = clr_idx_q;

endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// tb_param_register_file
//
// Directed bench for param_register_file. Two instances share every input:
//   dut     defaults (ZERO_REG=1, BYPASS=1)
//   dut_nb  ZERO_REG=0, BYPASS=0
// Inputs change 1 time unit after a rising edge. Combinational outputs are
// sampled 1 unit after that. Registered outputs are sampled 1 unit after the
// edge.
// -----------------------------------------------------------------------------
module tb_param_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              clear;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;

    logic [DATA_W-1:0] rd1, rd2, nb_rd1, nb_rd2;
    logic              ready, nb_ready;
    logic [ADDR_W-1:0] clr_idx, nb_clr_idx;

    int n_checks;
    int n_fail;

    param_register_file #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1), .read_data2(rd2),
        .ready(ready), .clr_idx(clr_idx)
    );

    param_register_file #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .reset(reset), .clear(clear), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(nb_rd1), .read_data2(nb_rd2),
        .ready(nb_ready), .clr_idx(nb_clr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle write, then the enable is dropped.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        reg_write  = 1'b1;
        write_reg  = addr;
        write_data = data;
        step();
        reg_write  = 1'b0;
    endtask

    // Count the edges until ready rises, bounded at 100 edges.
    task automatic measure_clear(output int edges);
        edges = 0;
        while (edges < 100) begin
            step();
            edges++;
            if (ready) break;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %0b expected 0", ready);
        end
        n_checks++;
        if (clr_idx !== 5'd0) begin
            n_fail++; $display("FAIL reset_clr_idx: got %0d expected 0", clr_idx);
        end
        step();
        step();
        n_checks++;
        if (clr_idx !== 5'd0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_held: clr_idx=%0d ready=%0b expected 0/0", clr_idx, ready);
        end
        n_checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            n_fail++; $display("FAIL reset_read: rd1=%h rd2=%h expected 0", rd1, rd2);
        end
        // Release. Each of the next 32 edges clears one entry.
        reset = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            logic [ADDR_W-1:0] exp_idx;
            logic              exp_rdy;
            step();
            exp_idx = ADDR_W'(k % 32);
            exp_rdy = (k == 32);
            n_checks++;
            if (ready !== exp_rdy || nb_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL release_ready edge %0d: got %0b/%0b expected %0b", k, ready, nb_ready, exp_rdy);
            end
            n_checks++;
            if (clr_idx !== exp_idx) begin
                n_fail++; $display("FAIL release_clr_idx edge %0d: got %0d expected %0d", k, clr_idx, exp_idx);
            end
        end
        // Every address reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            read_reg1 = ADDR_W'(i);
            read_reg2 = ADDR_W'(31 - i);
            #1;
            n_checks++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0 || nb_rd1 !== 32'h0 || nb_rd2 !== 32'h0) begin
                n_fail++;
                $display("FAIL cleared_read addr %0d: %h %h %h %h expected all 0", i, rd1, rd2, nb_rd1, nb_rd2);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_write_read();
        do_write(5'd7, 32'hDEADBEEF);
        read_reg1 = 5'd7;
        read_reg2 = 5'd7;
        #1;
        n_checks++;
        if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_r7: rd1=%h rd2=%h expected deadbeef", rd1, rd2);
        end
        n_checks++;
        if (nb_rd1 !== 32'hDEADBEEF || nb_rd2 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_r7_nb: rd1=%h rd2=%h expected deadbeef", nb_rd1, nb_rd2);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_bypass();
        // r3 holds 0. Write 0x12345678 while both ports read r3.
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'h12345678;
        read_reg1  = 5'd3;
        read_reg2  = 5'd3;
        #1;
        n_checks++;
        if (rd1 !== 32'h12345678 || rd2 !== 32'h12345678) begin
            n_fail++; $display("FAIL bypass_same_cycle: rd1=%h rd2=%h expected 12345678", rd1, rd2);
        end
        n_checks++;
        if (nb_rd1 !== 32'h0 || nb_rd2 !== 32'h0) begin
            n_fail++; $display("FAIL nobypass_old: rd1=%h rd2=%h expected 0", nb_rd1, nb_rd2);
        end
        // A read of a different address does not interact with the write.
        read_reg2 = 5'd7;
        #1;
        n_checks++;
        if (rd2 !== 32'hDEADBEEF || nb_rd2 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_other_addr: got %h/%h expected deadbeef", rd2, nb_rd2);
        end
        step();
        reg_write = 1'b0;
        #1;
        n_checks++;
        if (rd1 !== 32'h12345678 || nb_rd1 !== 32'h12345678) begin
            n_fail++; $display("FAIL after_edge_r3: got %h/%h expected 12345678", rd1, nb_rd1);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_zero_reg();
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'hFFFFFFFF;
        read_reg1  = 5'd0;
        #1;
        n_checks++;
        if (rd1 !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg_bypass: got %h expected 0", rd1);
        end
        step();
        reg_write = 1'b0;
        #1;
        n_checks++;
        if (rd1 !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg_after: got %h expected 0", rd1);
        end
        // ZERO_REG=0 instance: r0 is an ordinary register.
        n_checks++;
        if (nb_rd1 !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL r0_writable_nb: got %h expected ffffffff", nb_rd1);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_clear();
        int edges;
        for (int i = 1; i < 32; i++) begin
            do_write(ADDR_W'(i), 32'hA5000000 | 32'(i));
        end
        read_reg1 = 5'd5;
        read_reg2 = 5'd31;
        #1;
        n_checks++;
        if (rd1 !== 32'hA5000005 || rd2 !== 32'hA500001F) begin
            n_fail++; $display("FAIL fill: r5=%h r31=%h expected a5000005/a500001f", rd1, rd2);
        end
        // Pulse clear for one cycle.
        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || clr_idx !== 5'd0) begin
            n_fail++; $display("FAIL clear_start: ready=%0b clr_idx=%0d expected 0/0", ready, clr_idx);
        end
        n_checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            n_fail++; $display("FAIL read_during_clear: %h %h expected 0", rd1, rd2);
        end
        // 10 edges, then a clear request that must not restart the sweep.
        for (int k = 0; k < 10; k++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if (clr_idx !== 5'd11) begin
            n_fail++; $display("FAIL clear_in_clear: clr_idx=%0d expected 11", clr_idx);
        end
        // Late in the window (entry 5 already swept), try to write r5.
        for (int k = 0; k < 10; k++) step();
        do_write(5'd5, 32'h00000055);
        // 22 edges have been used since the clear edge. 10 more bring ready up.
        measure_clear(edges);
        n_checks++;
        if (edges !== 10) begin
            n_fail++; $display("FAIL clear_length: ready after %0d more edges expected 10", edges);
        end
        n_checks++;
        if (rd1 !== 32'h0 || nb_rd1 !== 32'h0) begin
            n_fail++; $display("FAIL dropped_write_r5: got %h/%h expected 0", rd1, nb_rd1);
        end
        n_checks++;
        if (rd2 !== 32'h0 || nb_rd2 !== 32'h0) begin
            n_fail++; $display("FAIL cleared_r31: got %h/%h expected 0", rd2, nb_rd2);
        end
        read_reg1 = 5'd0;
        #1;
        n_checks++;
        if (nb_rd1 !== 32'h0) begin
            n_fail++; $display("FAIL cleared_r0_nb: got %h expected 0", nb_rd1);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_clear();
        int edges;
        int guard;
        do_write(5'd9, 32'h0BADF00D);
        clear = 1'b1;
        step();
        clear = 1'b0;
        guard = 0;
        while (clr_idx !== 5'd10 && guard < 100) begin
            step();
            guard++;
        end
        n_checks++;
        if (clr_idx !== 5'd10) begin
            n_fail++; $display("FAIL reach_idx10: clr_idx=%0d expected 10", clr_idx);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (clr_idx !== 5'd0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: clr_idx=%0d ready=%0b expected 0/0", clr_idx, ready);
        end
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (clr_idx !== 5'd0) begin
            n_fail++; $display("FAIL restart_idx: clr_idx=%0d expected 0", clr_idx);
        end
        step();
        n_checks++;
        if (clr_idx !== 5'd1) begin
            n_fail++; $display("FAIL restart_first_edge: clr_idx=%0d expected 1", clr_idx);
        end
        measure_clear(edges);
        n_checks++;
        if (edges + 1 !== 32) begin
            n_fail++; $display("FAIL restart_length: ready after %0d edges expected 32", edges + 1);
        end
        read_reg1 = 5'd9;
        read_reg2 = 5'd7;
        #1;
        n_checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || nb_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_restart: r9=%h r7=%h nb_ready=%0b expected 0/0/1", rd1, rd2, nb_ready);
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        clear      = 1'b0;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;

        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_clear();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
